// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the execution controller and the ALU next to it:
// opcode values, instruction field widths and the controller state encoding.
package exec_ctrl_pkg;

  localparam int OPC_W = 4;
  localparam int IMM_W = 11;

  localparam logic [OPC_W-1:0] OP_NOP = 4'd0;
  localparam logic [OPC_W-1:0] OP_MOV = 4'd1;
  localparam logic [OPC_W-1:0] OP_JMP = 4'd2;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'd3;
  localparam logic [OPC_W-1:0] OP_HLT = 4'd4;
  localparam logic [OPC_W-1:0] OP_ADD = 4'd5;
  localparam logic [OPC_W-1:0] OP_SUB = 4'd6;
  localparam logic [OPC_W-1:0] OP_MUL = 4'd7;
  localparam logic [OPC_W-1:0] OP_NOT = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } exec_state_e;

  // Opcodes whose result comes back from the ALU into the accumulator.
  function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/exec_ctrl.sv
// Fetch/execute sequencer for a tiny accumulator machine: reads one
// instruction word per fetch, executes it in a single cycle, drives the ALU.
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int PC_W = 4,
  parameter int IW   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [IW-1:0]     imem_rdata,
  output logic [OPC_W-1:0]  alu_inst,
  output logic [IMM_W-1:0]  alu_arg1,
  output logic [IMM_W-1:0]  alu_arg2,
  output logic [IMM_W-1:0]  alu_acc,
  input  logic [IMM_W-1:0]  alu_out,
  output logic [IMM_W-1:0]  acc,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output exec_state_e       state_dbg
);

  exec_state_e       state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [IMM_W-1:0]  acc_q, acc_d;
  logic [IW-1:0]     ir_q, ir_d;

  logic [OPC_W-1:0]  ir_op;
  logic [IMM_W-1:0]  ir_imm;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   jump_tgt;

  assign ir_op    = ir_q[IW-1 -: OPC_W];
  assign ir_imm   = ir_q[IMM_W-1:0];
  assign pc_inc   = pc_q + PC_W'(1);
  assign jump_tgt = ir_imm[PC_W-1:0];

  // Read handshake: imem_req is high for every FETCH cycle with imem_addr
  // held at pc; the cycle imem_ack is high completes the read and imem_rdata
  // is captured. imem_ack in any other state is ignored.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    ir_d    = ir_q;

    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = run ? ST_FETCH : ST_IDLE;
        case (ir_op)
          OP_MOV: begin
            acc_d = ir_imm;
            pc_d  = pc_inc;
          end
          OP_JMP: pc_d = jump_tgt;
          OP_JZ:  pc_d = (acc_q == '0) ? jump_tgt : pc_inc;
          OP_HLT: state_d = ST_HALT;
          default: begin
            // NOP and reserved opcodes only advance; ALU ops also write back.
            if (is_alu_op(ir_op)) acc_d = alu_out;
            pc_d = pc_inc;
          end
        endcase
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      acc_q   <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
    end
  end

  assign imem_req  = (state_q == ST_FETCH);
  assign imem_addr = pc_q;
  assign alu_inst  = (state_q == ST_EXEC) ? ir_op : '0;
  assign alu_arg1  = ir_imm;
  assign alu_arg2  = '0;
  assign alu_acc   = acc_q;
  assign acc       = acc_q;
  assign pc        = pc_q;
  assign halted    = (state_q == ST_HALT);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: memory responder with programmable ack delay,
// a behavioural ALU, and hand-computed expectations per scenario.
module tb_exec_ctrl;
  import exec_ctrl_pkg::*;

  localparam int PC_W = 4;
  localparam int IW   = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  always #5 clk = ~clk;

  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack = 1'b0;
  logic [IW-1:0]     imem_rdata = '0;
  logic [3:0]        alu_inst;
  logic [10:0]       alu_arg1, alu_arg2, alu_acc, alu_out, acc;
  logic [PC_W-1:0]   pc;
  logic              halted;
  exec_state_e       state_dbg;

  exec_ctrl #(.PC_W(PC_W), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .alu_inst(alu_inst), .alu_arg1(alu_arg1), .alu_arg2(alu_arg2),
    .alu_acc(alu_acc), .alu_out(alu_out),
    .acc(acc), .pc(pc), .halted(halted), .state_dbg(state_dbg)
  );

  // ---------------- environment models ----------------
  logic [IW-1:0] mem [16];
  int ack_delay = 0;
  int wait_cnt = 0;
  bit spurious_ack = 1'b0;

  always @(negedge clk) begin
    if (imem_req) begin
      if (wait_cnt == ack_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr];
        wait_cnt   = 0;
      end else begin
        imem_ack = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      imem_ack   = spurious_ack;
      imem_rdata = {4'd1, 11'd77};
      wait_cnt   = 0;
    end
  end

  always_comb begin
    alu_out = '0;
    case (alu_inst)
      4'd5: alu_out = alu_acc + alu_arg1;
      4'd6: alu_out = alu_acc - alu_arg1;
      4'd7: alu_out = 11'(alu_acc * alu_arg1);
      4'd8: alu_out = ~alu_acc;
      default: alu_out = '0;
    endcase
  end

  int exec_cnt = 0;
  int fetch_cyc = 0;
  int stab_err = 0;
  bit prev_fetch = 1'b0;
  logic [PC_W-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (state_dbg == ST_EXEC) exec_cnt = exec_cnt + 1;
    if (state_dbg == ST_FETCH) begin
      fetch_cyc = fetch_cyc + 1;
      if (prev_fetch && (imem_addr !== prev_addr || imem_req !== 1'b1))
        stab_err = stab_err + 1;
    end
    prev_fetch = (state_dbg == ST_FETCH);
    prev_addr  = imem_addr;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [IW-1:0] ins(input logic [3:0] op, input logic [10:0] imm);
    return {op, imm};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int delay);
    rst_n = 1'b0;
    run = 1'b0;
    ack_delay = delay;
    spurious_ack = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    tick(1);
    exec_cnt = 0;
    fetch_cyc = 0;
    stab_err = 0;
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic wait_halt();
    int n = 0;
    while (!halted && n < 300) begin
      tick(1);
      n++;
    end
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  // Returns one cycle after the n-th EXEC cycle, so its effects are visible.
  task automatic wait_execs(input int n);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < 300) begin
      tick(1);
      cyc++;
      if (state_dbg == ST_EXEC) seen++;
    end
    chk("exec_seen", 32'(seen), 32'(n));
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset values
    do_reset(0);
    rst_n = 1'b0;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_alu_inst", 32'(alu_inst), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));

    // MOV 7; ADD 5; HLT
    do_reset(0);
    mem[0] = ins(OP_MOV, 11'd7);
    mem[1] = ins(OP_ADD, 11'd5);
    mem[2] = ins(OP_HLT, 11'd0);
    run = 1'b1;
    tick(1);
    chk("first_addr", 32'(imem_addr), 32'd0);
    chk("first_req", 32'(imem_req), 32'd1);
    wait_halt();
    chk("p1_acc", 32'(acc), 32'd12);
    chk("p1_pc", 32'(pc), 32'd2);
    chk("p1_execs", 32'(exec_cnt), 32'd3);
    chk("p1_fetch_cycles", 32'(fetch_cyc), 32'd3);
    run = 1'b0;
    tick(2);
    run = 1'b1;
    tick(3);
    chk("halt_acc_frozen", 32'(acc), 32'd12);
    chk("halt_pc_frozen", 32'(pc), 32'd2);
    chk("halt_req_low", 32'(imem_req), 32'd0);
    chk("halt_held", 32'(halted), 32'd1);

    // JZ taken: MOV 3; SUB 3; JZ 0
    do_reset(0);
    mem[0] = ins(OP_MOV, 11'd3);
    mem[1] = ins(OP_SUB, 11'd3);
    mem[2] = ins(OP_JZ, 11'd0);
    run = 1'b1;
    wait_execs(3);
    chk("jz_taken_pc", 32'(pc), 32'd0);
    chk("jz_taken_acc", 32'(acc), 32'd0);
    chk("jz_taken_addr", 32'(imem_addr), 32'd0);

    // JZ falls through: MOV 1; SUB 3 -> 2046
    do_reset(0);
    mem[0] = ins(OP_MOV, 11'd1);
    mem[1] = ins(OP_SUB, 11'd3);
    mem[2] = ins(OP_JZ, 11'd0);
    run = 1'b1;
    wait_execs(3);
    chk("jz_fall_pc", 32'(pc), 32'd3);
    chk("jz_fall_acc", 32'(acc), 32'd2046);

    // Ack delayed three cycles
    do_reset(3);
    mem[0] = ins(OP_MOV, 11'd2);
    mem[1] = ins(OP_ADD, 11'd4);
    mem[2] = ins(OP_HLT, 11'd0);
    run = 1'b1;
    wait_halt();
    chk("slow_acc", 32'(acc), 32'd6);
    chk("slow_execs", 32'(exec_cnt), 32'd3);
    chk("slow_fetch_cycles", 32'(fetch_cyc), 32'd12);
    chk("slow_stability", 32'(stab_err), 32'd0);

    // pc wraps after address 15
    do_reset(0);
    mem[0]  = ins(OP_JMP, 11'd15);
    mem[15] = ins(OP_NOP, 11'd0);
    run = 1'b1;
    wait_execs(1);
    chk("jmp_pc", 32'(pc), 32'd15);
    wait_execs(1);
    chk("wrap_pc", 32'(pc), 32'd0);
    chk("wrap_addr", 32'(imem_addr), 32'd0);

    // Reset mid-FETCH
    do_reset(5);
    mem[0] = ins(OP_MOV, 11'd7);
    run = 1'b1;
    wait_execs(1);
    tick(1);
    chk("pre_rst_acc", 32'(acc), 32'd7);
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_pc", 32'(pc), 32'd0);
    chk("midrst_acc", 32'(acc), 32'd0);
    chk("midrst_state", 32'(state_dbg), 32'(ST_IDLE));

    // run dropped during FETCH of MOV 9
    do_reset(2);
    mem[0] = ins(OP_MOV, 11'd9);
    mem[1] = ins(OP_MOV, 11'd5);
    run = 1'b1;
    tick(1);
    chk("drop_in_fetch", 32'(state_dbg), 32'(ST_FETCH));
    run = 1'b0;
    wait_execs(1);
    chk("drop_acc", 32'(acc), 32'd9);
    chk("drop_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("drop_req", 32'(imem_req), 32'd0);
    chk("drop_pc", 32'(pc), 32'd1);

    // Ack outside FETCH is ignored
    spurious_ack = 1'b1;
    tick(4);
    spurious_ack = 1'b0;
    chk("spur_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("spur_acc", 32'(acc), 32'd9);
    chk("spur_pc", 32'(pc), 32'd1);
    chk("arg2_zero", 32'(alu_arg2), 32'd0);

    // MUL, NOT and a reserved opcode
    do_reset(1);
    mem[0] = ins(OP_MOV, 11'd6);
    mem[1] = ins(OP_MUL, 11'd7);
    mem[2] = ins(OP_NOT, 11'd0);
    mem[3] = ins(4'd12, 11'd5);
    mem[4] = ins(OP_HLT, 11'd0);
    run = 1'b1;
    wait_execs(2);
    chk("mul_acc", 32'(acc), 32'd42);
    wait_halt();
    chk("not_acc", 32'(acc), 32'd2005);
    chk("rsvd_pc", 32'(pc), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 4, program counter width (program of 2^PC_W words).
REQ-002 SHALL have parameter IW, default 15, instruction width: [14:11] opcode, [10:0] immediate.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port run  in  1  level; high permits instruction execution.
REQ-006 SHALL have port imem_req  out  1  instruction-read request.
REQ-007 SHALL have port imem_addr  out  PC_W  read address (= pc).
REQ-008 SHALL have port imem_ack  in  1  read complete; imem_rdata valid this cycle.
REQ-009 SHALL have port imem_rdata  in  IW  instruction word.
REQ-010 SHALL have port alu_inst  out  4  opcode to ALU.
REQ-011 SHALL have ports alu_arg1, alu_arg2, alu_acc  out  11 each  ALU operands.
REQ-012 SHALL have port alu_out  in  11  ALU result.
REQ-013 SHALL have port acc  out  11  accumulator register.
REQ-014 SHALL have port pc  out  PC_W  program counter.
REQ-015 SHALL have port halted  out  1  high in HALT state.

Function
REQ-016 SHALL implement states IDLE, FETCH, EXEC, HALT.
REQ-017 IDLE: imem_req=0; go to FETCH when run=1.
REQ-018 FETCH: imem_req=1, imem_addr=pc held stable until imem_ack; on ack latch imem_rdata into instruction register, go to EXEC; no timeout.
REQ-019 EXEC lasts exactly one cycle; then FETCH if run=1, else IDLE.
REQ-020 Opcode 0 NOP: pc+1.
REQ-021 Opcode 1 MOV: acc<=imm, pc+1.
REQ-022 Opcode 2 JMP: pc<=imm[PC_W-1:0].
REQ-023 Opcode 3 JZ: if acc==0 pc<=imm[PC_W-1:0], else pc+1.
REQ-024 Opcode 4 HLT: go to HALT, pc unchanged.
REQ-025 Opcodes 5-8 (add, sub, mul, not): acc<=alu_out, pc+1; result taken unmodified, no clamping in this block.
REQ-026 Opcodes 9-15 reserved: execute as NOP.
REQ-027 alu_inst = latched opcode in EXEC, 0 otherwise; alu_arg1 = latched imm; alu_acc = acc; alu_arg2 = 0 always.
REQ-028 pc+1 SHALL wrap modulo 2^PC_W (max -> 0).
REQ-029 run falling during FETCH: complete fetch and EXEC, then IDLE; no instruction is abandoned.
REQ-030 HALT: imem_req=0, acc/pc frozen; exits only via reset.
REQ-031 Minimum throughput: one instruction per 2 cycles (imem_ack in first FETCH cycle).
REQ-032 imem_ack outside FETCH SHALL be ignored.

Reset
REQ-033 rst_n low SHALL immediately force state=IDLE, pc=0, acc=0, instruction register=0, imem_req=0, halted=0, alu_inst=0, including mid-FETCH.
REQ-034 First fetch after reset release SHALL be address 0, starting the cycle after run is sampled high.

Structure
REQ-035 Opcode constants (NOP, MOV, JMP, JZ, HLT, ADD=5, SUB=6, MUL=7, NOT=8) and state encoding SHALL live in a shared package used by exec_ctrl and the ALU.
REQ-036 No sub-module; exec_ctrl instantiates nothing and connects to the ALU at the top level.

Verification
REQ-037 Reset, run=1, program [MOV 7; ADD 5; HLT], ack same cycle -> acc=12, pc=2, halted=1 after 6 cycles.
REQ-038 [MOV 3; SUB 3; JZ 0] -> after JZ pc=0; with MOV 1 at addr 0 instead, JZ falls through to pc=3.
REQ-039 imem_ack delayed 3 cycles -> imem_req and imem_addr stable throughout, EXEC once per instruction.
REQ-040 PC_W=4, NOP at address 15 -> next imem_addr=0.
REQ-041 rst_n pulsed low mid-FETCH -> imem_req drops same instant; pc=0, acc=0, state IDLE.
REQ-042 run dropped during FETCH of MOV 9 -> acc=9 written, then IDLE with imem_req=0.
